// File: rtl/dmem_bus_bridge.sv
// Bridges the CPU's single-cycle data port onto a registered req/ack data bus, stalling the CPU until completion.
// Optional REQ-state abort timer is enabled by defining DMEM_BUS_BRIDGE_TIMEOUT_EN.
module dmem_bus_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_daddr,
    input  logic [31:0]       cpu_dwdata,
    input  logic [3:0]        cpu_dwe,
    input  logic              cpu_dre,
    output logic [31:0]       cpu_drdata,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err,
    output logic              err_flag,
    input  logic              err_clr
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              err_set;
    logic              access;

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
    logic [31:0]       cnt_q, cnt_d;
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^cpu_daddr[1:0];
`else
    logic              unused_bits;
    assign unused_bits = (^cpu_daddr[1:0]) ^ (TIMEOUT_CYCLES == 0);
`endif

    assign access = (cpu_dwe != 4'h0) || cpu_dre;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        rdata_d     = rdata_q;
        err_set     = 1'b0;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    bus_addr_d = {cpu_daddr[ADDR_W-1:2], 2'b00};
                    // Store wins over a simultaneous load request.
                    if (cpu_dwe != 4'h0) begin
                        bus_we_d    = 1'b1;
                        bus_be_d    = cpu_dwe;
                        bus_wdata_d = cpu_dwdata;
                    end else begin
                        bus_we_d = 1'b0;
                        bus_be_d = 4'hF;
                    end
                    bus_req_d = 1'b1;
                    state_d   = REQ;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
                    cnt_d     = 32'd0;
`endif
                end
            end
            REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d = bus_rdata;
                    end
                    err_set = bus_err;
                    state_d = DONE;
                end
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
                else if ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES)) begin
                    bus_req_d = 1'b0;
                    rdata_d   = 32'h0000_0000;
                    err_set   = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new error outranks a coincident clear request.
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
            cnt_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cpu_stall  = (state_q == REQ) || ((state_q == IDLE) && access);
    assign cpu_drdata = rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;
    assign err_flag   = err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed table, hand-written corner sequences, randomized traffic vs. a transaction-level model.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_daddr;
    logic [31:0] cpu_dwdata;
    logic [3:0]  cpu_dwe;
    logic        cpu_dre;
    logic [31:0] cpu_drdata;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        err_flag;
    logic        err_clr;

    dmem_bus_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_daddr(cpu_daddr), .cpu_dwdata(cpu_dwdata), .cpu_dwe(cpu_dwe), .cpu_dre(cpu_dre),
        .cpu_drdata(cpu_drdata), .cpu_stall(cpu_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .err_flag(err_flag), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: last load data returned, and sticky error state.
    logic [31:0] m_drdata;
    logic        m_err;

    typedef struct {
        logic [3:0]  dwe;
        logic        dre;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        berr;
        logic        clr;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_drdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_dwe    = 4'h0;
        cpu_dre    = 1'b0;
        cpu_daddr  = $urandom;
        cpu_dwdata = $urandom;
    endtask

    // Entered at a negedge with the DUT in IDLE; leaves at the negedge after DONE (DUT back in IDLE).
    task automatic run_txn(input logic [3:0] dwe, input logic dre, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                           input logic berr, input logic clr, input logic [31:0] exp_addr,
                           input logic exp_we, input logic [3:0] exp_be,
                           input logic [31:0] exp_drdata, input logic exp_err);
        int stall_cnt;
        cpu_dwe    = dwe;
        cpu_dre    = dre;
        cpu_daddr  = addr;
        cpu_dwdata = wdata;
        #1;
        check("stall_idle", cpu_stall, 1'b1);
        stall_cnt = 1;
        @(negedge clk);
        for (int w = 0; w <= waits; w++) begin
            check("req_held", bus_req, 1'b1);
            if (cpu_stall) stall_cnt++;
            if (w == 0) begin
                check("bus_addr", bus_addr, exp_addr);
                check("bus_we", bus_we, exp_we);
                check("bus_be", bus_be, exp_be);
                if (exp_we) check("bus_wdata", bus_wdata, wdata);
            end
            if (w == waits) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
                bus_err   = berr;
                err_clr   = clr;
            end
            @(negedge clk);
        end
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        err_clr   = 1'b0;
        bus_rdata = $urandom;
        check("done_stall", cpu_stall, 1'b0);
        check("done_req", bus_req, 1'b0);
        check("drdata", cpu_drdata, exp_drdata);
        check("err_flag", err_flag, exp_err);
        check("stall_cycles", stall_cnt, 2 + waits);
        cpu_idle();
        @(negedge clk);
        check("single_txn", bus_req, 1'b0);
        $display("txn addr=%h we=%b be=%h waits=%0d drdata=%h err=%b", addr, exp_we, exp_be, waits,
                 cpu_drdata, err_flag);
    endtask

    initial begin
        tbl[0] = '{4'h0, 1'b1, 32'h0000_1006, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0,
                   32'h0000_1004, 1'b0, 4'hF, 32'hCAFE_F00D, 1'b0};
        tbl[1] = '{4'h4, 1'b0, 32'h0000_2001, 32'h00AB_0000, 3, 32'h5555_5555, 1'b0, 1'b0,
                   32'h0000_2000, 1'b1, 4'h4, 32'hCAFE_F00D, 1'b0};
        tbl[2] = '{4'hF, 1'b1, 32'h0000_3000, 32'h1122_3344, 1, 32'hDEAD_BEEF, 1'b0, 1'b0,
                   32'h0000_3000, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0};
        tbl[3] = '{4'h0, 1'b1, 32'h0000_0043, 32'h0, 2, 32'h1234_5678, 1'b1, 1'b0,
                   32'h0000_0040, 1'b0, 4'hF, 32'h1234_5678, 1'b1};
        tbl[4] = '{4'h0, 1'b1, 32'h0000_0080, 32'h0, 0, 32'h0BAD_F00D, 1'b1, 1'b1,
                   32'h0000_0080, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b1};
        tbl[5] = '{4'h3, 1'b0, 32'h0000_0102, 32'hA5A5_A5A5, 0, 32'hFFFF_FFFF, 1'b0, 1'b1,
                   32'h0000_0100, 1'b1, 4'h3, 32'h0BAD_F00D, 1'b0};
        tbl[6] = '{4'h0, 1'b1, 32'hFFFF_FFFF, 32'h0, 4, 32'h0000_0000, 1'b0, 1'b0,
                   32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0000_0000, 1'b0};

        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        bus_err   = 1'b0;
        err_clr   = 1'b0;
        cpu_dwe   = 4'h0;
        cpu_dre   = 1'b0;
        cpu_daddr = 32'h0;
        cpu_dwdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", bus_req, 1'b0);
        check("rst_we", bus_we, 1'b0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_be", bus_be, 4'h0);
        check("rst_drdata", cpu_drdata, 32'h0);
        check("rst_err", err_flag, 1'b0);
        check("rst_stall", cpu_stall, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].dwe, tbl[i].dre, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].rdata,
                    tbl[i].berr, tbl[i].clr, tbl[i].exp_addr, tbl[i].exp_we, tbl[i].exp_be,
                    tbl[i].exp_drdata, tbl[i].exp_err);
        end
        m_drdata = 32'h0;
        m_err    = 1'b0;

        // Error set, then a standalone clear pulse while idle.
        run_txn(4'h1, 1'b0, 32'h0000_0010, 32'h0000_00EE, 1, 32'h0, 1'b1, 1'b0,
                32'h0000_0010, 1'b1, 4'h1, m_drdata, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", err_flag, 1'b0);
        $display("txn err_clr pulse err=%b", err_flag);

        // Stray ack while idle must not start or finish anything.
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        @(negedge clk);
        bus_ack = 1'b0;
        check("stray_stall", cpu_stall, 1'b0);
        check("stray_req", bus_req, 1'b0);
        check("stray_drdata", cpu_drdata, m_drdata);
        $display("txn stray ack idle drdata=%h", cpu_drdata);

        // Reset landing between edges while a request is outstanding.
        cpu_dre   = 1'b1;
        cpu_daddr = 32'h0000_5000;
        @(negedge clk);
        check("pre_rst_req", bus_req, 1'b1);
        cpu_idle();
        #2 reset = 1'b1;
        #1;
        check("rst_async_req", bus_req, 1'b0);
        check("rst_async_stall", cpu_stall, 1'b0);
        @(negedge clk);
        reset   = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h9999_9999;
        @(negedge clk);
        bus_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("late_ack_stall", cpu_stall, 1'b0);
            check("late_ack_req", bus_req, 1'b0);
            check("late_ack_drdata", cpu_drdata, 32'h0);
            @(negedge clk);
        end
        m_drdata = 32'h0;
        m_err    = 1'b0;
        $display("txn reset mid-REQ req=%b", bus_req);

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
        begin
            int req_cycles = 0;
            cpu_dre   = 1'b1;
            cpu_daddr = 32'h0000_6000;
            @(negedge clk);
            for (int k = 0; k < 12 && bus_req; k++) begin
                req_cycles++;
                @(negedge clk);
            end
            check("to_req_cycles", req_cycles, 4);
            check("to_stall", cpu_stall, 1'b0);
            check("to_drdata", cpu_drdata, 32'h0);
            check("to_err", err_flag, 1'b1);
            cpu_idle();
            @(negedge clk);
            m_drdata = 32'h0;
            m_err    = 1'b1;
            $display("txn timeout req_cycles=%0d err=%b", req_cycles, err_flag);
        end
`endif

        // Randomized traffic against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  dwe;
            logic        dre, berr, clr, is_st;
            logic [31:0] addr, wdata, rdata;
            int          waits;
            dwe   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            dre   = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            waits = $urandom_range(0, 4);
            berr  = ($urandom_range(0, 9) == 0);
            clr   = ($urandom_range(0, 4) == 0);
            is_st = (dwe != 4'h0);
            if (!is_st && !dre) begin
                cpu_dwe = 4'h0;
                cpu_dre = 1'b0;
                cpu_daddr = addr;
                #1;
                check("rnd_idle_stall", cpu_stall, 1'b0);
                @(negedge clk);
                check("rnd_idle_req", bus_req, 1'b0);
                $display("txn rnd %0d no access", n);
            end else begin
                if (!is_st) m_drdata = rdata;
                m_err = berr | (m_err & ~clr);
                run_txn(dwe, dre, addr, wdata, waits, rdata, berr, clr, addr & 32'hFFFF_FFFC,
                        is_st, is_st ? dwe : 4'hF, m_drdata, m_err);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the single-cycle CPU's data port (daddr/dwdata/dwe/drdata).
- Converts each CPU load/store into a registered request/acknowledge transaction on the data bus, which serves RAM and peripherals with variable latency.
- Returns load data to the CPU.
- Holds the CPU with a stall until the bus access completes, so that PC and register writeback do not advance early.

Parameters:
- ADDR_W, 32, address width on both sides.
- TIMEOUT_CYCLES, 255, maximum REQ-state cycles before abort. Used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_daddr  input  ADDR_W  CPU data address (ALU result).
- cpu_dwdata  input  32  CPU store data.
- cpu_dwe  input  4  CPU byte write enables; non-zero means store.
- cpu_dre  input  1  CPU load request.
- cpu_drdata  output  32  load data returned to the CPU.
- cpu_stall  output  1  high means the CPU must hold PC and suppress register write.
- bus_req  output  1  bus request, registered.
- bus_we  output  1  1 = write, 0 = read, registered.
- bus_addr  output  ADDR_W  word-aligned address, registered.
- bus_wdata  output  32  write data, registered.
- bus_be  output  4  byte enables, registered.
- bus_ack  input  1  single-cycle completion pulse from the bus.
- bus_rdata  input  32  read data, valid when bus_ack=1.
- bus_err  input  1  error qualifier, sampled with bus_ack.
- err_flag  output  1  sticky error indicator.
- err_clr  input  1  synchronous clear for err_flag.

Behaviour:
- Access is defined as access = (cpu_dwe != 0) || cpu_dre. A store takes priority when both are set.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - cpu_stall = access (combinational).
  - On access: latch bus_addr = {cpu_daddr[ADDR_W-1:2], 2'b00}.
  - Store: bus_we=1, bus_be=cpu_dwe, bus_wdata=cpu_dwdata.
  - Load: bus_we=0, bus_be=4'hF.
  - Set bus_req=1, go to REQ.
- REQ:
  - cpu_stall=1; bus_req is held at 1 with all other bus outputs stable.
  - On bus_ack: bus_req<=0.
  - On a load, capture bus_rdata into an internal rdata register.
  - If bus_err=1, set err_flag. Go to DONE.
- DONE:
  - cpu_stall=0 and cpu_drdata = rdata register, so the CPU commits on this edge.
  - Unconditionally go to IDLE. A new access is evaluated the following cycle, so the same access is never issued twice.
- cpu_drdata holds its last value outside DONE. The CPU samples it only when not stalled.
- Minimum latency is 3 cycles per access (IDLE, REQ with immediate ack, DONE). Each additional wait cycle adds one cycle.
- bus_ack seen outside REQ is ignored.
- err_flag clearing and setting:
  - err_clr clears err_flag.
  - When err_clr and a set event occur in the same cycle, set wins.
- Reset: asynchronous, active-high.
  - state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata=0, err_flag=0.
  - cpu_stall follows IDLE combinationally.
  - Reset asserted mid-REQ drops bus_req immediately, without waiting for a clock edge. A late bus_ack after reset is ignored.
- Misaligned addresses: low address bits are dropped. Lane selection is the responsibility of cpu_dwe and of the CPU's load formatter.

Optional Feature:
- Macro: DMEM_BUS_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter clears on entry to REQ and increments each REQ cycle without bus_ack.
  - When the counter reaches TIMEOUT_CYCLES: bus_req<=0, rdata<=32'h0000_0000, err_flag<=1, go to DONE.
  - bus_ack arriving in the same cycle as the timeout takes precedence: it is a normal completion, not a timeout.
- Undefined: no counter; REQ waits indefinitely for bus_ack.

Test Plan:
- Load with ack after 0 waits:
  - Stimulus: cpu_dre=1, cpu_daddr=32'h0000_1006, bus_rdata=32'hCAFE_F00D.
  - Response: bus_addr=32'h0000_1004, bus_be=4'hF, bus_we=0; cpu_stall high for 2 cycles; cpu_drdata=32'hCAFE_F00D in DONE.
- Byte store with 3 wait cycles:
  - Stimulus: cpu_dwe=4'b0100, cpu_dwdata=32'h00AB_0000.
  - Response: bus_we=1, bus_be=4'b0100, bus_req held 4 cycles, stall total 5 cycles, err_flag=0.
- Store and load both asserted:
  - Stimulus: cpu_dwe=4'hF, cpu_dre=1.
  - Response: write issued (bus_we=1); exactly one bus transaction.
- Error and clear:
  - Stimulus: bus_ack=1 with bus_err=1; a later err_clr=1 pulse; then err_clr=1 together with a new error.
  - Response: err_flag=1 after the error; err_flag=0 the cycle after err_clr; err_flag remains 1 when err_clr coincides with a new error.
- Reset mid-REQ:
  - Stimulus: assert reset between clock edges while bus_req=1.
  - Response: bus_req=0 immediately; state IDLE; a subsequent stray bus_ack causes no DONE.
- With DMEM_BUS_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4:
  - Stimulus: no ack.
  - Response: bus_req drops after 4 REQ cycles, cpu_drdata=0, err_flag=1, CPU released.
